keypad_emulator: RTL and testbench

Synthesizable 4x4 matrix-keypad model that answers a column-scanning keypad controller by pulling the matching row low. Software or a test sequencer hands it one key code per transaction. The emulator then runs a full press lifecycle for that key: bounce-in, hold, bounce-out, release gap. It replaces the physical keypad and pull-ups for hardware-in-loop checks of the keypad FSM and the dual-digit display path.

---
 rtl/keypad_emulator_if.sv | 29 ++
 rtl/keypad_emulator.sv | 202 ++++++++++++++++++++
 tb/tb_keypad_emulator.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/keypad_emulator_if.sv
`default_nettype none
// ============================================================================
// Module      : keypad_emulator_if
// Description : Bundle between a keypad scanner / test sequencer and the
//               4x4 keypad emulator. The master drives columns and press
//               requests; the slave (emulator) answers with rows and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface keypad_emulator_if;
  logic [3:0]  cols;         // column drive, active-low
  logic [3:0]  rows;         // row sense, active-low, idle 4'b1111
  logic        key_valid;    // press request
  logic [3:0]  key_code;     // hex key to press
  logic [15:0] hold_cycles;  // stable-closed duration, 0 behaves as 1
  logic        key_ready;    // emulator idle, request can be taken
  logic        done;         // one-cycle pulse at end of a press lifecycle
  logic        contact;      // registered switch state, 1 = closed

  modport master (
    output cols, key_valid, key_code, hold_cycles,
    input  rows, key_ready, done, contact
  );

  modport slave (
    input  cols, key_valid, key_code, hold_cycles,
    output rows, key_ready, done, contact
  );
endinterface
`default_nettype wire

// File: rtl/keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : keypad_emulator
// Description : 4x4 matrix keypad model. One request runs a full press
//               lifecycle (bounce-in, hold, bounce-out, release gap) and the
//               selected row is pulled low whenever the contact is closed and
//               the scanner drives the matching column low.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_emulator #(
  parameter int BOUNCE_CYCLES  = 8,
  parameter int BOUNCE_TOGGLES = 3,
  parameter int GAP_CYCLES     = 16
) (
  input  logic          clk,
  input  logic          reset,   // asynchronous, active-low
  keypad_emulator_if.slave kp
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_BIN  = 3'd1,
    S_HOLD = 3'd2,
    S_BOUT = 3'd3,
    S_GAP  = 3'd4
  } state_t;

  // With no bounce the phase counter is never used; keep it one bit wide.
  localparam int              c_PHASES       = (BOUNCE_TOGGLES > 0) ? 2 * BOUNCE_TOGGLES : 1;
  localparam int              c_PW           = (c_PHASES > 1) ? $clog2(c_PHASES) : 1;
  localparam logic [c_PW-1:0] c_LAST_PHASE   = c_PW'(c_PHASES - 1);
  localparam logic [15:0]     c_BOUNCE_LOAD  = 16'(BOUNCE_CYCLES - 1);
  localparam logic [15:0]     c_GAP_LOAD     = 16'(GAP_CYCLES - 1);
  localparam bit              c_HAS_BOUNCE   = (BOUNCE_TOGGLES > 0);

  state_t          r_state;
  logic [15:0]     r_dur;      // cycles left in current state/phase, minus one
  logic [c_PW-1:0] r_phase;    // bounce phase index k
  logic            r_contact;
  logic [3:0]      r_code;     // latched key code
  logic [15:0]     r_hold;     // latched hold duration, minus one

  state_t          w_state_nx;
  logic [15:0]     w_dur_nx;
  logic [c_PW-1:0] w_phase_nx;
  logic [c_PW-1:0] w_phase_inc;
  logic            w_contact_nx;
  logic [3:0]      w_code_nx;
  logic [15:0]     w_hold_nx;
  logic            w_done;
  logic [1:0]      w_row_sel;
  logic [1:0]      w_col_sel;
  logic [3:0]      w_rows;

  // Translate the latched key code into its (row, col) position on the pad.
  always_comb begin
    w_row_sel = 2'd0;
    w_col_sel = 2'd0;
    case (r_code)
      4'h1: begin w_row_sel = 2'd0; w_col_sel = 2'd0; end
      4'h2: begin w_row_sel = 2'd0; w_col_sel = 2'd1; end
      4'h3: begin w_row_sel = 2'd0; w_col_sel = 2'd2; end
      4'hA: begin w_row_sel = 2'd0; w_col_sel = 2'd3; end
      4'h4: begin w_row_sel = 2'd1; w_col_sel = 2'd0; end
      4'h5: begin w_row_sel = 2'd1; w_col_sel = 2'd1; end
      4'h6: begin w_row_sel = 2'd1; w_col_sel = 2'd2; end
      4'hB: begin w_row_sel = 2'd1; w_col_sel = 2'd3; end
      4'h7: begin w_row_sel = 2'd2; w_col_sel = 2'd0; end
      4'h8: begin w_row_sel = 2'd2; w_col_sel = 2'd1; end
      4'h9: begin w_row_sel = 2'd2; w_col_sel = 2'd2; end
      4'hC: begin w_row_sel = 2'd2; w_col_sel = 2'd3; end
      4'hE: begin w_row_sel = 2'd3; w_col_sel = 2'd0; end
      4'h0: begin w_row_sel = 2'd3; w_col_sel = 2'd1; end
      4'hF: begin w_row_sel = 2'd3; w_col_sel = 2'd2; end
      4'hD: begin w_row_sel = 2'd3; w_col_sel = 2'd3; end
      default: begin w_row_sel = 2'd0; w_col_sel = 2'd0; end
    endcase
  end

  // Next-state, counter reloads and contact level for every state/phase change.
  always_comb begin
    w_state_nx   = r_state;
    w_dur_nx     = r_dur;
    w_phase_nx   = r_phase;
    w_contact_nx = r_contact;
    w_code_nx    = r_code;
    w_hold_nx    = r_hold;
    w_done       = 1'b0;
    w_phase_inc  = r_phase + 1'b1;

    case (r_state)
      S_IDLE: begin
        w_contact_nx = 1'b0;
        if (kp.key_valid) begin
          w_code_nx    = kp.key_code;
          w_hold_nx    = (kp.hold_cycles == 16'd0) ? 16'd0 : kp.hold_cycles - 16'd1;
          w_contact_nx = 1'b1;   // first bounce phase and hold both start closed
          w_phase_nx   = '0;
          if (c_HAS_BOUNCE) begin
            w_state_nx = S_BIN;
            w_dur_nx   = c_BOUNCE_LOAD;
          end else begin
            w_state_nx = S_HOLD;
            w_dur_nx   = (kp.hold_cycles == 16'd0) ? 16'd0 : kp.hold_cycles - 16'd1;
          end
        end
      end

      S_BIN: begin
        if (r_dur != 16'd0) begin
          w_dur_nx = r_dur - 16'd1;
        end else if (r_phase == c_LAST_PHASE) begin
          w_state_nx   = S_HOLD;
          w_dur_nx     = r_hold;
          w_contact_nx = 1'b1;
        end else begin
          w_phase_nx   = w_phase_inc;
          w_dur_nx     = c_BOUNCE_LOAD;
          w_contact_nx = ~w_phase_inc[0];   // closed on even phases
        end
      end

      S_HOLD: begin
        if (r_dur != 16'd0) begin
          w_dur_nx = r_dur - 16'd1;
        end else if (c_HAS_BOUNCE) begin
          w_state_nx   = S_BOUT;
          w_phase_nx   = '0;
          w_dur_nx     = c_BOUNCE_LOAD;
          w_contact_nx = 1'b0;
        end else begin
          w_state_nx   = S_GAP;
          w_dur_nx     = c_GAP_LOAD;
          w_contact_nx = 1'b0;
        end
      end

      S_BOUT: begin
        if (r_dur != 16'd0) begin
          w_dur_nx = r_dur - 16'd1;
        end else if (r_phase == c_LAST_PHASE) begin
          w_state_nx   = S_GAP;
          w_dur_nx     = c_GAP_LOAD;
          w_contact_nx = 1'b0;
        end else begin
          w_phase_nx   = w_phase_inc;
          w_dur_nx     = c_BOUNCE_LOAD;
          w_contact_nx = w_phase_inc[0];    // open on even phases
        end
      end

      S_GAP: begin
        w_contact_nx = 1'b0;
        if (r_dur != 16'd0) begin
          w_dur_nx = r_dur - 16'd1;
        end else begin
          w_state_nx = S_IDLE;
          w_done     = 1'b1;
        end
      end

      default: begin
        w_state_nx   = S_IDLE;
        w_contact_nx = 1'b0;
      end
    endcase
  end

  // State, counters, contact and latched request; reset drops any press at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_dur     <= 16'd0;
      r_phase   <= '0;
      r_contact <= 1'b0;
      r_code    <= 4'd0;
      r_hold    <= 16'd0;
    end else begin
      r_state   <= w_state_nx;
      r_dur     <= w_dur_nx;
      r_phase   <= w_phase_nx;
      r_contact <= w_contact_nx;
      r_code    <= w_code_nx;
      r_hold    <= w_hold_nx;
    end
  end

  // Row sense follows the column drive combinationally; only the selected row can go low.
  always_comb begin
    w_rows = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      w_rows[r] = ~(r_contact && (w_row_sel == 2'(r)) && (kp.cols[w_col_sel] == 1'b0));
    end
  end

  assign kp.rows      = w_rows;
  assign kp.key_ready = (r_state == S_IDLE);
  assign kp.done      = w_done;
  assign kp.contact   = r_contact;

endmodule
`default_nettype wire

// File: tb/tb_keypad_emulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_emulator
// Description : Self-checking bench for keypad_emulator. Two instances (with
//               and without bounce) are driven through directed and random
//               press lifecycles and compared cycle by cycle against a
//               timeline model of the press profile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_emulator;

  localparam int A_BC = 8, A_TOG = 3, A_GAP = 16;
  localparam int B_BC = 8, B_TOG = 0, B_GAP = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  cols_t;
  logic        kv_t;
  logic [3:0]  kc_t;
  logic [15:0] hc_t;
  int          sel;

  always #5 clk = ~clk;

  keypad_emulator_if ifa ();
  keypad_emulator_if ifb ();

  keypad_emulator #(.BOUNCE_CYCLES(A_BC), .BOUNCE_TOGGLES(A_TOG), .GAP_CYCLES(A_GAP)) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .kp    (ifa)
  );

  keypad_emulator #(.BOUNCE_CYCLES(B_BC), .BOUNCE_TOGGLES(B_TOG), .GAP_CYCLES(B_GAP)) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .kp    (ifb)
  );

  assign ifa.cols        = cols_t;
  assign ifb.cols        = cols_t;
  assign ifa.key_valid   = kv_t && (sel == 0);
  assign ifb.key_valid   = kv_t && (sel == 1);
  assign ifa.key_code    = kc_t;
  assign ifb.key_code    = kc_t;
  assign ifa.hold_cycles = hc_t;
  assign ifb.hold_cycles = hc_t;

  logic [3:0] rows_o;
  logic       ready_o, done_o, contact_o;
  assign rows_o    = (sel == 1) ? ifb.rows      : ifa.rows;
  assign ready_o   = (sel == 1) ? ifb.key_ready : ifa.key_ready;
  assign done_o    = (sel == 1) ? ifb.done      : ifa.done;
  assign contact_o = (sel == 1) ? ifb.contact   : ifa.contact;

  int n_total = 0;
  int n_bad   = 0;

  // Pad layout, row-major: index = row*4 + col.
  logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pos_of(input logic [3:0] code);
    for (int i = 0; i < 16; i++) if (layout[i] == code) return i;
    return 0;
  endfunction

  // Contact level k cycles after acceptance, from the press profile timeline.
  function automatic bit model_contact(input int k, input int bc, input int tog, input int h);
    int s;
    s = 2 * bc * tog;
    if (k < s)         return ((k / bc) % 2) == 0;
    if (k < s + h)     return 1'b1;
    if (k < 2 * s + h) return ((k - s - h) / bc) % 2 == 1;
    return 1'b0;
  endfunction

  // One press on DUT d. Called just after a falling edge with the DUT idle.
  // keep: key_valid stays high with junk code/hold during the press.
  // cyc : columns walk one low bit per cycle instead of random patterns.
  // abort_k: cycle index at which reset is pulsed mid-press (-1 = never).
  task automatic press(input int d, input logic [3:0] code, input int hold,
                       input bit keep, input bit cyc, input int abort_k);
    int bc, tog, gap, h, s, len, p, row, col;
    bit ec;
    logic [3:0] er;
    bc  = (d == 1) ? B_BC  : A_BC;
    tog = (d == 1) ? B_TOG : A_TOG;
    gap = (d == 1) ? B_GAP : A_GAP;
    h   = (hold == 0) ? 1 : hold;
    s   = 2 * bc * tog;
    len = 2 * s + h + gap;
    p   = pos_of(code);
    row = p / 4;
    col = p % 4;

    sel  = d;
    kv_t = 1'b1;
    kc_t = code;
    hc_t = 16'(hold);
    #1;
    check_eq("ready_before_accept", {31'b0, ready_o}, 32'd1);
    @(posedge clk);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk);
      cols_t = cyc ? ~(4'b0001 << (k % 4)) : 4'($urandom);
      if (k < len) begin
        if (keep) begin
          kc_t = 4'($urandom);
          hc_t = 16'($urandom);
        end else begin
          kv_t = 1'b0;
        end
      end
      #1;
      if (k == abort_k) begin
        #1;
        reset = 1'b0;
        kv_t  = 1'b0;
        #1;
        check_eq("abort_rows",    {28'b0, rows_o},    32'hF);
        check_eq("abort_ready",   {31'b0, ready_o},   32'd1);
        check_eq("abort_contact", {31'b0, contact_o}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clk);
          #1;
          check_eq("abort_no_done", {31'b0, done_o},  32'd0);
          check_eq("abort_idle",    {31'b0, ready_o}, 32'd1);
        end
        return;
      end
      ec = model_contact(k, bc, tog, h);
      er = 4'hF;
      if (ec && cols_t[col] == 1'b0) er[row] = 1'b0;
      check_eq("contact", {31'b0, contact_o}, {31'b0, ec});
      check_eq("rows",    {28'b0, rows_o},    {28'b0, er});
      check_eq("done",    {31'b0, done_o},    {31'b0, (k == len - 1)});
      check_eq("ready",   {31'b0, ready_o},   {31'b0, (k == len)});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset  = 1'b0;
    kv_t   = 1'b0;
    kc_t   = 4'h0;
    hc_t   = 16'd0;
    cols_t = 4'hF;
    sel    = 0;

    repeat (2) @(negedge clk);
    cols_t = 4'b0000;
    #1;
    for (int d = 0; d < 2; d++) begin
      sel = d;
      #1;
      check_eq("reset_rows",    {28'b0, rows_o},    32'hF);
      check_eq("reset_ready",   {31'b0, ready_o},   32'd1);
      check_eq("reset_contact", {31'b0, contact_o}, 32'd0);
      check_eq("reset_done",    {31'b0, done_o},    32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    #1;

    // Code 6 without bounce, walking columns, 116-cycle lifecycle.
    press(1, 4'h6, 100, 1'b0, 1'b1, -1);
    // Full bounce profile, code 8.
    press(0, 4'h8, 200, 1'b0, 1'b0, -1);
    // Back-to-back with key_valid held high and junk inputs mid-press.
    press(0, 4'h6, 20, 1'b1, 1'b0, -1);
    press(0, 4'h8, 15, 1'b1, 1'b0, -1);
    kv_t = 1'b0;
    // hold_cycles = 0 behaves as a single closed cycle.
    press(0, 4'h3, 0, 1'b0, 1'b0, -1);
    press(1, 4'hA, 0, 1'b0, 1'b0, -1);
    // Reset in the middle of HOLD, then a normal press of D.
    press(0, 4'h6, 200, 1'b0, 1'b0, 100);
    press(0, 4'hD, 30, 1'b0, 1'b0, -1);
    // Random presses on either instance.
    for (int i = 0; i < 10; i++) begin
      press(int'($urandom_range(0, 1)), 4'($urandom), int'($urandom_range(0, 40)),
            1'($urandom_range(0, 1)), 1'b0, -1);
    end
    kv_t = 1'b0;

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
